weight_bram_loader: RTL and testbench
=====================================

WEIGHT_BRAM_LOADER -- requirements
Module: weight_bram_loader

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter DEPTH, default 16: number of 16-bit weight words per frame (4-bit address).
REQ-003 SHALL have input clk, 1 bit: rising-edge clock for all logic.
REQ-004 SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have input in_valid, 1 bit: byte stream valid.
REQ-006 SHALL have input in_data, 8 bits: byte stream payload.
REQ-007 SHALL have output in_ready, 1 bit: a byte transfers when in_valid and in_ready are both high on a rising edge.
REQ-008 SHALL have input rd_addr, 4 bits: weight read address from the MAC engine.
REQ-009 SHALL have output rd_data, 16 bits signed: the weight at rd_addr, two cycles after the address is presented.
REQ-010 SHALL have output loaded, 1 bit: high when memory holds a complete, checksum-valid frame.
REQ-011 SHALL have output busy, 1 bit: high while a frame is in progress (states LO, HI, CHK).
REQ-012 SHALL have output crc_err, 1 bit: sticky flag set when the last frame failed its checksum.

Function
REQ-013 SHALL implement the FSM states IDLE, LO, HI and CHK.
REQ-014 In IDLE, SHALL discard every accepted byte except HDR_BYTE; an accepted HDR_BYTE SHALL go to LO, clear the word counter and checksum, and clear loaded and crc_err.
REQ-015 In LO, SHALL latch the accepted byte as the low byte, XOR it into the checksum and go to HI.
REQ-016 In HI, the accepted byte SHALL form the word {byte, low byte}, be written to memory[word counter] on that same edge, and be XORed into the checksum.
REQ-017 After the HI write, SHALL return to LO if the word counter is below DEPTH-1, otherwise go to CHK; the word counter SHALL increment on every HI write.
REQ-018 In CHK, SHALL compare the accepted byte with the 8-bit running XOR of all 2*DEPTH data bytes and return to IDLE.
REQ-019 On a CHK match, SHALL set loaded=1 and crc_err=0; on a mismatch, SHALL set loaded=0 and crc_err=1.
REQ-020 SHALL drive in_ready=1 in every state when not in reset; there is no backpressure other than during reset.
REQ-021 SHALL keep the state unchanged on any cycle with in_valid=0, with no timeout.
REQ-022 SHALL treat a HDR_BYTE received in LO, HI or CHK as data, never as a resync.
REQ-023 SHALL always serve reads from current memory contents, including during a load; loaded=0 marks such reads as untrusted.
REQ-024 Read path SHALL be rd_addr registered at edge N, memory output registered at edge N+1, so rd_data is valid at edge N+2 and a new address may be presented every cycle.
REQ-025 A write and a read of the same address on one edge SHALL return the old data (read-first).
REQ-026 SHALL keep memory writes and the read pipeline fully independent, so simultaneous stream input and reads proceed with no stall.

Reset
REQ-027 On rst, SHALL set state=IDLE, word counter=0, checksum=0, loaded=0, crc_err=0, rd_data=0, both read pipeline registers=0 and in_ready=0.
REQ-028 SHALL NOT clear memory contents on rst.
REQ-029 A reset mid-frame SHALL abandon the frame, leaving the words already written in memory and loaded=0.
REQ-030 in_ready SHALL return to 1 on the first cycle after rst deasserts.

Verification
REQ-031 Frame A5, words k*0x0101+0x0100 for k=0..15 (little-endian), correct XOR -> loaded=1 and crc_err=0 one cycle after the checksum byte; rd_addr=3 -> rd_data=0x0403 two cycles later.
REQ-032 Same frame with the checksum byte inverted -> loaded=0, crc_err=1 and state IDLE; a following good frame -> crc_err=0 and loaded=1.
REQ-033 Bytes 00, 13, 5A before A5, with valid gaps of 0-3 cycles throughout -> leading bytes ignored and the frame still loads correctly.
REQ-034 Frame containing data byte A5 (word 7=0xA5A5) -> no resync and rd_addr=7 -> 0xA5A5.
REQ-035 rst asserted after word 5 of a frame -> loaded=0, busy=0, rd_data=0; words 0-4 remain readable after rst.
REQ-036 Back-to-back rd_addr 0..15 sweep while a new frame writes word 2 at the moment rd_addr=2 is read -> every read has 2-cycle latency and the colliding read returns the old value.

Source files
------------

// File: rtl/weight_bram_loader.sv
// weight_bram_loader
// Receives a framed byte stream (header, 2*DEPTH little-endian data bytes,
// XOR checksum) and writes the 16-bit weights into a small block RAM. The MAC
// engine reads the RAM through an independent two-stage registered read port.
// Memory contents survive reset; only control state and the read pipeline
// are cleared.

`timescale 1ns/1ps

module weight_bram_loader #(
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int unsigned DEPTH    = 16,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic [AW-1:0]      rd_addr,
    output logic signed [15:0] rd_data,
    output logic               loaded,
    output logic               busy,
    output logic               crc_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    // Control state
    state_t        r_state;
    logic [AW-1:0] r_wcnt;
    logic [7:0]    r_csum;
    logic [7:0]    r_lo;
    logic          r_loaded;
    logic          r_crc_err;
    logic          r_in_ready;

    // Storage and read pipeline
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_addr;
    logic [15:0]   r_rd_data;

    // Next-state signals
    state_t        w_state_next;
    logic [AW-1:0] w_wcnt_next;
    logic [7:0]    w_csum_next;
    logic [7:0]    w_lo_next;
    logic          w_loaded_next;
    logic          w_crc_err_next;
    logic          w_wr_en;
    logic [15:0]   w_wr_word;
    logic          w_accept;

    assign w_accept = in_valid & r_in_ready;

    // Frame parser: decides the next state and what an accepted byte updates
    always_comb begin
        w_state_next   = r_state;
        w_wcnt_next    = r_wcnt;
        w_csum_next    = r_csum;
        w_lo_next      = r_lo;
        w_loaded_next  = r_loaded;
        w_crc_err_next = r_crc_err;
        w_wr_en        = 1'b0;
        w_wr_word      = {in_data, r_lo};

        if (w_accept) begin
            unique case (r_state)
                IDLE: begin
                    // Anything other than the marker is line noise between frames
                    if (in_data == HDR_BYTE) begin
                        w_state_next   = LO;
                        w_wcnt_next    = '0;
                        w_csum_next    = 8'h00;
                        w_loaded_next  = 1'b0;
                        w_crc_err_next = 1'b0;
                    end
                end
                LO: begin
                    w_lo_next    = in_data;
                    w_csum_next  = r_csum ^ in_data;
                    w_state_next = HI;
                end
                HI: begin
                    w_wr_en      = 1'b1;
                    w_csum_next  = r_csum ^ in_data;
                    w_wcnt_next  = r_wcnt + AW'(1);
                    w_state_next = (r_wcnt == LAST_WORD) ? CHK : LO;
                end
                CHK: begin
                    w_loaded_next  = (in_data == r_csum);
                    w_crc_err_next = (in_data != r_csum);
                    w_state_next   = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Control registers with synchronous reset; in_ready drops only during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wcnt     <= '0;
            r_csum     <= 8'h00;
            r_lo       <= 8'h00;
            r_loaded   <= 1'b0;
            r_crc_err  <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wcnt     <= w_wcnt_next;
            r_csum     <= w_csum_next;
            r_lo       <= w_lo_next;
            r_loaded   <= w_loaded_next;
            r_crc_err  <= w_crc_err_next;
            r_in_ready <= 1'b1;
        end
    end

    // Memory write port; no reset so weights survive an abandoned frame
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_wcnt] <= w_wr_word;
        end
    end

    // Read pipeline: address register then data register. Sampling r_mem with
    // a non-blocking read makes a same-edge write to that address read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_rd_data <= 16'h0000;
        end else begin
            r_rd_addr <= rd_addr;
            r_rd_data <= r_mem[r_rd_addr];
        end
    end

    assign in_ready = r_in_ready;
    assign rd_data  = r_rd_data;
    assign loaded   = r_loaded;
    assign crc_err  = r_crc_err;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_weight_bram_loader.sv
// Bench for weight_bram_loader: random frames, gaps and read addresses. A
// byte-position reference model predicts every cycle's outputs into a
// scoreboard queue that a separate monitor drains; directed checks cover the
// fixed scenarios with constant expectations.

`timescale 1ns/1ps

module tb_weight_bram_loader;

    localparam logic [7:0] HDR   = 8'hA5;
    localparam int         DEPTH = 16;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic [3:0]  rd_addr  = 4'h0;
    logic        in_ready;
    logic [15:0] rd_data;
    logic        loaded;
    logic        busy;
    logic        crc_err;

    int n_checks = 0;
    int n_fail   = 0;

    weight_bram_loader #(
        .HDR_BYTE (HDR),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .loaded   (loaded),
        .busy     (busy),
        .crc_err  (crc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          rd_known;
        logic [15:0] rd;
        logic        loaded;
        logic        crc;
        logic        busy;
        logic        rdy;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_pos    = -1;  // byte index within the frame body, -1 = between frames
    logic [7:0]  m_cs     = 8'h00;
    logic [7:0]  m_lo     = 8'h00;
    logic        m_loaded = 1'b0;
    logic        m_crc    = 1'b0;
    logic        m_rdy    = 1'b0;
    logic [3:0]  m_prev   = 4'h0;
    bit          model_on = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) model_on = 1'b1;
            if (model_on) begin
                if (rst) begin
                    e.rd_known = 1'b1;
                    e.rd       = 16'h0000;
                    m_prev     = 4'h0;
                    m_pos      = -1;
                    m_cs       = 8'h00;
                    m_loaded   = 1'b0;
                    m_crc      = 1'b0;
                    m_rdy      = 1'b0;
                end else begin
                    // Read sees memory as it was before this edge's write
                    e.rd_known = m_known[m_prev];
                    e.rd       = m_mem[m_prev];
                    m_prev     = rd_addr;
                    if (in_valid && m_rdy) begin
                        if (m_pos < 0) begin
                            if (in_data == HDR) begin
                                m_pos    = 0;
                                m_cs     = 8'h00;
                                m_loaded = 1'b0;
                                m_crc    = 1'b0;
                            end
                        end else if (m_pos < 2 * DEPTH) begin
                            m_cs = m_cs ^ in_data;
                            if (m_pos % 2 == 0) begin
                                m_lo = in_data;
                            end else begin
                                m_mem[m_pos / 2]   = {in_data, m_lo};
                                m_known[m_pos / 2] = 1'b1;
                            end
                            m_pos++;
                        end else begin
                            m_loaded = (in_data == m_cs);
                            m_crc    = !m_loaded;
                            m_pos    = -1;
                        end
                    end
                    m_rdy = 1'b1;
                end
                e.loaded = m_loaded;
                e.crc    = m_crc;
                e.busy   = (m_pos >= 0);
                e.rdy    = m_rdy;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: one expectation per clock, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.rd_known) chk("sb_rd_data", rd_data, e.rd);
                chk("sb_loaded", loaded, e.loaded);
                chk("sb_crc_err", crc_err, e.crc);
                chk("sb_busy", busy, e.busy);
                chk("sb_in_ready", in_ready, e.rdy);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [15:0] fw [DEPTH];
    bit          gaps_on = 1'b0;

    task automatic cyc(input logic v, input logic [7:0] d, input logic [3:0] a);
        in_valid = v;
        in_data  = d;
        rd_addr  = a;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = gaps_on ? int'($urandom_range(0, 3)) : 0;
        repeat (g) cyc(1'b0, 8'($urandom), 4'($urandom));
        cyc(1'b1, b, 4'($urandom));
    endtask

    function automatic logic [7:0] frame_cs();
        logic [7:0] c = 8'h00;
        for (int k = 0; k < DEPTH; k++) c = c ^ fw[k][7:0] ^ fw[k][15:8];
        return c;
    endfunction

    task automatic send_frame(input bit bad);
        logic [7:0] c = frame_cs();
        send_byte(HDR);
        for (int k = 0; k < DEPTH; k++) begin
            send_byte(fw[k][7:0]);
            send_byte(fw[k][15:8]);
        end
        send_byte(bad ? ~c : c);
        in_valid = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < DEPTH; k++) fw[k] = 16'($urandom);
    endtask

    task automatic read_word(input logic [3:0] a, input logic [15:0] exp, input string name);
        cyc(1'b0, 8'h00, a);
        cyc(1'b0, 8'h00, a);
        chk(name, rd_data, exp);
    endtask

    initial begin
        logic [15:0] old2;
        logic [7:0]  bytes [$];
        bit          bad;

        // Reset
        rst = 1'b1;
        repeat (3) cyc(1'b0, 8'h00, 4'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_loaded", loaded, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_crc_err", crc_err, 1'b0);
        chk("rst_rd_data", rd_data, 16'h0000);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 4'h0);
        chk("rdy_after_rst", in_ready, 1'b1);

        // Frame A, good checksum
        for (int k = 0; k < DEPTH; k++) fw[k] = 16'(k * 16'h0101 + 16'h0100);
        send_frame(1'b0);
        chk("A_loaded", loaded, 1'b1);
        chk("A_crc_err", crc_err, 1'b0);
        read_word(4'd3, 16'h0403, "A_rd3");

        // Same frame with inverted checksum, then good again
        send_frame(1'b1);
        chk("bad_loaded", loaded, 1'b0);
        chk("bad_crc_err", crc_err, 1'b1);
        chk("bad_busy", busy, 1'b0);
        send_frame(1'b0);
        chk("good2_loaded", loaded, 1'b1);
        chk("good2_crc_err", crc_err, 1'b0);

        // Leading junk and random gaps
        gaps_on = 1'b1;
        fill_random();
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h5A);
        send_frame(1'b0);
        chk("junk_loaded", loaded, 1'b1);
        read_word(4'd9, fw[9], "junk_rd9");

        // Marker byte inside data must not resync
        fill_random();
        fw[7] = 16'hA5A5;
        fw[2][7:0] = HDR;
        send_frame(1'b0);
        chk("hdr_data_loaded", loaded, 1'b1);
        read_word(4'd7, 16'hA5A5, "hdr_data_rd7");

        // Reset mid-frame after words 0..5
        gaps_on = 1'b0;
        fill_random();
        send_byte(HDR);
        for (int k = 0; k < 6; k++) begin
            send_byte(fw[k][7:0]);
            send_byte(fw[k][15:8]);
        end
        rst = 1'b1;
        cyc(1'b0, 8'h00, 4'h0);
        chk("mid_rst_loaded", loaded, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_data", rd_data, 16'h0000);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 4'h0);
        for (int k = 0; k < 5; k++) read_word(4'(k), fw[k], "mid_rst_keep");

        // Read sweep colliding with the write of word 2
        old2 = fw[2];
        fill_random();
        if (fw[2] == old2) fw[2] = ~old2;
        bytes.delete();
        bytes.push_back(HDR);
        for (int k = 0; k < DEPTH; k++) begin
            bytes.push_back(fw[k][7:0]);
            bytes.push_back(fw[k][15:8]);
        end
        bytes.push_back(frame_cs());
        for (int i = 0; i < bytes.size() + 4; i++) begin
            cyc((i < bytes.size()) ? 1'b1 : 1'b0,
                (i < bytes.size()) ? bytes[i] : 8'h00,
                (i >= 3 && i < 19) ? 4'(i - 3) : 4'h0);
            if (i == 6) chk("collide_old", rd_data, old2);
        end
        chk("sweep_loaded", loaded, 1'b1);
        read_word(4'd2, fw[2], "collide_new");

        // Random frames, some corrupted
        repeat (6) begin
            gaps_on = ($urandom_range(0, 1) == 1);
            fill_random();
            bad = ($urandom_range(0, 3) == 0);
            send_frame(bad);
            chk("rnd_loaded", loaded, !bad);
            chk("rnd_crc_err", crc_err, bad);
        end

        repeat (4) cyc(1'b0, 8'h00, 4'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
